// File: rtl/pipe_hazard_tracker.sv
// Tracks destination-register state for the instructions past ID, forwards the youngest
// producer's result to each read port, and flags load-use hazards with a saturating stall count.
module pipe_hazard_tracker #(
  parameter  int DATA_W     = 32,
  parameter  int ADDR_W     = 5,
  parameter  int DEPTH      = 3,
  parameter  int NRD        = 2,
  parameter  int LOAD_READY = 2,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    flush,
  input  logic                    id_valid,
  input  logic                    id_wen,
  input  logic [ADDR_W-1:0]       id_waddr,
  input  logic                    id_is_load,
  input  logic [NRD-1:0]          rd_used,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  input  logic [NRD*DATA_W-1:0]   rf_data,
  input  logic [DEPTH*DATA_W-1:0] stage_data,
  output logic [NRD*DATA_W-1:0]   fwd_data,
  output logic [NRD*SEL_W-1:0]    fwd_sel,
  output logic                    load_use_stall,
  output logic [DEPTH-1:0]        slot_valid,
  output logic [15:0]             stall_cnt
);

  logic [DEPTH-1:0]  r_v;
  logic [DEPTH-1:0]  r_wen;
  logic [DEPTH-1:0]  r_ld;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [15:0]       r_stall_cnt;

  logic [NRD*DATA_W-1:0] w_fwd_data;
  logic [NRD*SEL_W-1:0]  w_fwd_sel;
  logic [NRD-1:0]        w_port_ld;
  logic                  w_stall;

  // Scan oldest to youngest so the youngest matching slot is the last one written.
  always_comb begin
    w_fwd_data = rf_data;
    w_fwd_sel  = '0;
    w_port_ld  = '0;
    w_stall    = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (r_v[k] && r_wen[k] && rd_used[i] &&
            (rd_addr[i*ADDR_W +: ADDR_W] != '0) &&
            (r_addr[k] == rd_addr[i*ADDR_W +: ADDR_W])) begin
          w_fwd_sel[i*SEL_W +: SEL_W]    = SEL_W'(k + 1);
          w_fwd_data[i*DATA_W +: DATA_W] = stage_data[k*DATA_W +: DATA_W];
          w_port_ld[i]                   = r_ld[k] && (k < LOAD_READY);
        end
      end
      w_stall = w_stall | w_port_ld[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v         <= '0;
      r_wen       <= '0;
      r_ld        <= '0;
      r_stall_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) r_addr[k] <= '0;
    end else if (!hold) begin
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k]    <= r_v[k-1];
        r_wen[k]  <= r_wen[k-1];
        r_ld[k]   <= r_ld[k-1];
        r_addr[k] <= r_addr[k-1];
      end
      // A stalled, flushed or absent ID instruction enters the pipe as a bubble.
      if (flush || w_stall || !id_valid) begin
        r_v[0]    <= 1'b0;
        r_wen[0]  <= 1'b0;
        r_ld[0]   <= 1'b0;
        r_addr[0] <= '0;
      end else begin
        r_v[0]    <= 1'b1;
        r_wen[0]  <= id_wen;
        r_ld[0]   <= id_is_load;
        r_addr[0] <= id_waddr;
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign fwd_data       = w_fwd_data;
  assign fwd_sel        = w_fwd_sel;
  assign load_use_stall = w_stall;
  assign slot_valid     = r_v;
  assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Directed and random checks of pipe_hazard_tracker against a queue-based pipeline model,
// plus a deep-pipeline instance that drives the stall counter into saturation.
module tb_pipe_hazard_tracker;

  typedef struct packed {
    logic       v;
    logic       wen;
    logic [4:0] addr;
    logic       ld;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, hold, flush, id_valid, id_wen, id_is_load;
  logic [4:0]  id_waddr;
  logic [1:0]  rd_used;
  logic [9:0]  rd_addr;
  logic [63:0] rf_data;
  logic [95:0] stage_data;
  logic [63:0] fwd_data;
  logic [3:0]  fwd_sel;
  logic        load_use_stall;
  logic [2:0]  slot_valid;
  logic [15:0] stall_cnt;

  logic        sat_rst;
  logic [63:0] sat_fwd_data;
  logic [7:0]  sat_fwd_sel;
  logic        sat_stall;
  logic [14:0] sat_slot_valid;
  logic [15:0] sat_cnt;

  int   n_assert = 0;
  int   n_fail   = 0;
  ent_t pipe[$];
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  pipe_hazard_tracker dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_wen(id_wen), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .rd_used(rd_used), .rd_addr(rd_addr), .rf_data(rf_data), .stage_data(stage_data),
    .fwd_data(fwd_data), .fwd_sel(fwd_sel), .load_use_stall(load_use_stall),
    .slot_valid(slot_valid), .stall_cnt(stall_cnt)
  );

  // Every cycle presents a load to r8 whose consumer is r8, so the load stalls in 15 of 16 cycles.
  pipe_hazard_tracker #(.DEPTH(15), .LOAD_READY(15)) sat_dut (
    .clk(clk), .rst(sat_rst), .hold(1'b0), .flush(1'b0), .id_valid(1'b1),
    .id_wen(1'b1), .id_waddr(5'd8), .id_is_load(1'b1),
    .rd_used(2'b01), .rd_addr(10'd8), .rf_data(64'd0), .stage_data(480'd0),
    .fwd_data(sat_fwd_data), .fwd_sel(sat_fwd_sel), .load_use_stall(sat_stall),
    .slot_valid(sat_slot_valid), .stall_cnt(sat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe = {};
    for (int k = 0; k < 3; k++) pipe.push_back('0);
    exp_cnt = 16'd0;
  endtask

  task automatic set_id(input logic v, input logic wen, input logic [4:0] a, input logic ld);
    id_valid = v; id_wen = wen; id_waddr = a; id_is_load = ld;
  endtask

  task automatic set_rd(input logic [1:0] used, input logic [4:0] a0, input logic [4:0] a1);
    rd_used = used; rd_addr = {a1, a0};
  endtask

  // Check one cycle against the model, then let the edge happen and advance the model.
  task automatic cyc();
    logic exp_stall;
    rf_data    = {$urandom, $urandom};
    stage_data = {$urandom, $urandom, $urandom};
    #1;
    exp_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int         win;
      logic       port_stall;
      logic [4:0] a;
      win = -1;
      a   = rd_addr[i*5 +: 5];
      for (int k = 0; k < 3; k++)
        if (win < 0 && rd_used[i] && a != 5'd0 && pipe[k].v && pipe[k].wen && pipe[k].addr == a)
          win = k;
      port_stall = (win >= 0) && pipe[win].ld && (win < 2);
      chk($sformatf("fwd_sel%0d", i), 32'(fwd_sel[i*2 +: 2]), (win < 0) ? 32'd0 : 32'(win + 1));
      if (!port_stall)
        chk($sformatf("fwd_data%0d", i), fwd_data[i*32 +: 32],
            (win < 0) ? rf_data[i*32 +: 32] : stage_data[win*32 +: 32]);
      exp_stall = exp_stall | port_stall;
    end
    chk("load_use_stall", 32'(load_use_stall), 32'(exp_stall));
    chk("slot_valid", 32'(slot_valid), {29'd0, pipe[2].v, pipe[1].v, pipe[0].v});
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
    @(posedge clk);
    if (rst) model_reset();
    else if (!hold) begin
      if (exp_stall && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      void'(pipe.pop_back());
      if (flush || exp_stall || !id_valid) pipe.push_front('0);
      else pipe.push_front({1'b1, id_wen, id_waddr, id_is_load});
    end
    @(negedge clk);
  endtask

  initial begin
    int          j;
    int          at_max;
    logic [15:0] sat_exp;
    rst = 1'b1; sat_rst = 1'b1; hold = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0); set_rd(2'b00, 0, 0);
    rf_data = '0; stage_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;

    // Idle after reset: everything comes from the register file.
    set_rd(2'b11, 5'd5, 5'd9);
    repeat (2) cyc();

    // ALU result to r5, consumed the next cycle and the one after.
    set_id(1, 1, 5'd5, 0); set_rd(2'b00, 0, 0); cyc();
    set_id(0, 0, 0, 0);    set_rd(2'b01, 5'd5, 5'd0); cyc();
    cyc(); cyc();

    // Load to r8 followed immediately by a reader of r8.
    set_id(1, 1, 5'd8, 1); set_rd(2'b00, 0, 0); cyc();
    set_id(1, 0, 0, 0);    set_rd(2'b10, 5'd0, 5'd8);
    repeat (4) cyc();

    // Two writers to r3 with an unrelated one between; then writers to r0.
    set_rd(2'b00, 0, 0);
    set_id(1, 1, 5'd3, 0); cyc();
    set_id(1, 1, 5'd7, 0); cyc();
    set_id(1, 1, 5'd3, 0); cyc();
    set_id(0, 0, 0, 0); set_rd(2'b11, 5'd3, 5'd3); cyc();
    set_id(1, 1, 5'd0, 0); set_rd(2'b00, 0, 0); cyc();
    set_id(1, 1, 5'd0, 1); cyc();
    set_id(0, 0, 0, 0); set_rd(2'b11, 5'd0, 5'd0); cyc(); cyc();

    // Hold for four cycles on top of a pending load-use, then a flush.
    set_id(1, 1, 5'd9, 1); set_rd(2'b00, 0, 0); cyc();
    set_id(1, 0, 0, 0);    set_rd(2'b01, 5'd9, 5'd0);
    hold = 1'b1; repeat (4) cyc();
    hold = 1'b0; repeat (2) cyc();
    set_id(1, 1, 5'd4, 0); set_rd(2'b00, 0, 0);
    flush = 1'b1; cyc();
    flush = 1'b0; set_rd(2'b11, 5'd4, 5'd9); cyc(); cyc();

    // Random traffic over a small register range so matches are frequent.
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      hold  = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom_range(0, 7)),
             $urandom_range(0, 2) == 0);
      set_rd(2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cyc();
    end
    rst = 1'b0; hold = 1'b0; flush = 1'b0;

    // Reset arriving while a load-use stall is active.
    set_id(1, 1, 5'd8, 1); set_rd(2'b00, 0, 0); cyc();
    set_id(1, 0, 0, 0);    set_rd(2'b01, 5'd8, 5'd0); cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; cyc(); cyc();

    // Saturation on the deep instance: edge j stalls unless j % 16 == 1.
    sat_rst = 1'b0;
    j = 0; at_max = 0; sat_exp = 16'd0;
    while (at_max < 5 && j < 80000) begin
      @(posedge clk);
      j++;
      if (j % 16 != 1) begin
        if (sat_exp != 16'hFFFF) sat_exp = sat_exp + 16'd1;
        else at_max++;
      end
      @(negedge clk);
      if (sat_exp >= 16'hFFFD || j % 8192 == 0) chk("sat_cnt", 32'(sat_cnt), 32'(sat_exp));
    end
    if (j % 16 == 0) begin
      @(posedge clk); j++; @(negedge clk);
    end
    chk("sat_stall_before_rst", 32'(sat_stall), 32'd1);
    sat_rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("sat_cnt_after_rst", 32'(sat_cnt), 32'd0);
    chk("sat_slots_after_rst", 32'(sat_slot_valid), 32'd0);
    chk("sat_stall_after_rst", 32'(sat_stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
